pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
- Sequences the 5-stage ARM pipeline (IF, ID, EX, MEM, WB) around the ID-stage control-signal decoder.
- Keeps a shadow copy of the destination register, write-enable and load flag for the EX, MEM and WB stages.
- From these it produces load-use stalls, NOP-insertion control, branch flush and operand-forwarding selects.
- Sits beside the ID stage; drives the PC/IF-ID enables, the control-word NOP mux and the three ID operand muxes.

Parameters:
- NREG_W, 4, register-index width (R0..R15).
- PC_REG, 15, index of the PC; never forwarded and never a hazard source.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction (0 for NOP, IR == 0)
- id_rn  in  4  first source register index
- id_rn_used  in  1  rn is read
- id_rm  in  4  second source register index
- id_rm_used  in  1  rm is read (register-offset / register operand)
- id_rd_src  in  4  store-data source register index
- id_rd_src_used  in  1  store reads rd as data
- id_dest  in  4  destination register of the ID instruction (R14 for BL)
- id_dest_we  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load (LI set, R/W = read)
- id_br_taken  in  1  branch resolved taken in ID
- pc_ld  out  1  PC load enable
- ifid_ld  out  1  IF/ID register load enable
- cu_nop_sel  out  1  1 = inject all-zero control word into ID/EX
- if_flush  out  1  1 = load NOP into IF/ID
- fwd_a_sel  out  2  rn source: 00 RF, 01 EX, 10 MEM, 11 WB
- fwd_b_sel  out  2  rm source, same encoding
- fwd_c_sel  out  2  store-data source, same encoding
- stall_cnt  out  STALL_CNT_W  count of stall cycles, saturating

Behaviour:
Shadow pipeline:
- Three registered stages: ex_*, mem_*, wb_*. Each holds {dest[3:0], we, is_load}.
- Every clock edge, mem <= ex and wb <= mem.
- ex <= ID fields gated: ex_we = id_valid & id_dest_we & ~stall; ex_is_load = id_valid & id_is_load & ~stall.
- A stalled cycle therefore places a bubble in EX.
- No enable on the shadow pipeline; it always advances, matching the real EX/MEM/WB registers.

Hazard match:
- match(S, r) = S_we & (S_dest == r) & (r != PC_REG).

Load-use stall (combinational):
- stall = id_valid & ex_is_load & ex_we & [(id_rn_used & ex_dest == id_rn) | (id_rm_used & ex_dest == id_rm) | (id_rd_src_used & ex_dest == id_rd_src)], with dest != PC_REG.
- stall = 1 gives pc_ld = 0, ifid_ld = 0, cu_nop_sel = 1.
- Stall lasts exactly 1 cycle per load-use pair. Next cycle the load is in MEM and is forwarded from there.

Forwarding (combinational, per operand; priority EX > MEM > WB > RF):
- Select 01 if match(ex), else 10 if match(mem), else 11 if match(wb), else 00.
- Selects are valid even when the operand's *_used flag is 0; consumers ignore them.
- During a stall the selects are don't-care.

Branch flush:
- if_flush = id_br_taken & id_valid & ~stall.
- Stall has priority: the branch holds in ID and re-resolves next cycle.
- Flush does not affect pc_ld (pc_ld stays 1 so the PC loads the target).

Counter:
- stall_cnt increments on each clock edge with stall = 1.
- Saturates at all-ones; no wrap.

Defaults and reset:
- Outside stall: pc_ld = 1, ifid_ld = 1, cu_nop_sel = 0.
- reset_n low asynchronously clears all shadow stages and stall_cnt.
- During and after reset: stall = 0, pc_ld = 1, ifid_ld = 1, cu_nop_sel = 0, if_flush = 0, all fwd_*_sel = 00, stall_cnt = 0.
- Reset mid-stall drops the stall immediately.

Boundary cases:
- Back-to-back writes to the same register: the youngest wins by priority.
- Load followed by an unrelated instruction: no stall.
- BL writing R14 is forwarded like any other write.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_MEM = 2'b10, FWD_WB = 2'b11
  - PC_REG
  - shadow-stage struct {dest, we, is_load}
- One sub-module, fwd_select: pure combinational priority match for a single operand, instantiated three times.

Test Plan:
1. Reset: reset_n = 0 mid-run -> all outputs at reset values, stall_cnt = 0. Release, then idle NOPs -> pc_ld = 1, fwd = 00.
2. ALU forwarding: ADD R1 then SUB R2,R1,R3 -> fwd_a_sel = 01. One NOP between them -> 10. Two NOPs -> 11. Three NOPs -> 00.
3. Load-use: LDR R4 then ADD R5,R4,R4 -> exactly 1 cycle of pc_ld = 0, ifid_ld = 0, cu_nop_sel = 1. Next cycle fwd_a_sel = fwd_b_sel = 10. stall_cnt = 1.
4. Store data: LDR R6 then STR R6,[R7] -> 1-cycle stall, then fwd_c_sel = 10.
5. Branch: taken B in ID with no hazard -> if_flush = 1 for 1 cycle. Taken B coincident with a load-use stall -> if_flush = 0 that cycle, 1 the next.
6. Priority and PC: ADD R1; ADD R1; SUB uses R1 -> fwd_a_sel = 01. A write to R15 followed by a read of R15 -> fwd_a_sel = 00, no stall. Drive 2^16 + 5 stalls -> stall_cnt = 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the ID-stage hazard unit: forwarding encodings, PC index
// and the per-stage shadow record of what each later stage will write.
package pipe_pkg;
  localparam int          NREG_W  = 4;
  localparam logic [NREG_W-1:0] PC_REG = 4'd15;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [NREG_W-1:0] dest;
    logic              we;
    logic              is_load;
  } shadow_t;

  // The PC is read from its own path, so it never counts as a producer.
  function automatic logic hit(input shadow_t s, input logic [NREG_W-1:0] r);
    return s.we && (s.dest == r) && (r != PC_REG);
  endfunction
endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage <-> hazard unit bundle; master is the ID stage, slave the hazard unit.
interface pipeline_hazard_unit_if #(parameter int STALL_CNT_W = 16);
  import pipe_pkg::*;

  logic              id_valid;
  logic [NREG_W-1:0] id_rn;
  logic              id_rn_used;
  logic [NREG_W-1:0] id_rm;
  logic              id_rm_used;
  logic [NREG_W-1:0] id_rd_src;
  logic              id_rd_src_used;
  logic [NREG_W-1:0] id_dest;
  logic              id_dest_we;
  logic              id_is_load;
  logic              id_br_taken;

  logic                   pc_ld;
  logic                   ifid_ld;
  logic                   cu_nop_sel;
  logic                   if_flush;
  logic [1:0]             fwd_a_sel;
  logic [1:0]             fwd_b_sel;
  logic [1:0]             fwd_c_sel;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rn, id_rn_used, id_rm, id_rm_used, id_rd_src,
           id_rd_src_used, id_dest, id_dest_we, id_is_load, id_br_taken,
    input  pc_ld, ifid_ld, cu_nop_sel, if_flush, fwd_a_sel, fwd_b_sel,
           fwd_c_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_rn_used, id_rm, id_rm_used, id_rd_src,
           id_rd_src_used, id_dest, id_dest_we, id_is_load, id_br_taken,
    output pc_ld, ifid_ld, cu_nop_sel, if_flush, fwd_a_sel, fwd_b_sel,
           fwd_c_sel, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// Forwarding source for one ID operand; youngest matching producer wins.
module fwd_select
  import pipe_pkg::*;
(
  input  shadow_t           i_ex,
  input  shadow_t           i_mem,
  input  shadow_t           i_wb,
  input  logic [NREG_W-1:0] i_reg,
  output logic [1:0]        o_sel
);
  always_comb begin
    o_sel = FWD_RF;
    if      (hit(i_ex,  i_reg)) o_sel = FWD_EX;
    else if (hit(i_mem, i_reg)) o_sel = FWD_MEM;
    else if (hit(i_wb,  i_reg)) o_sel = FWD_WB;
  end
endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, branch flush and operand forwarding for the 5-stage pipeline,
// driven from a shadow copy of the EX/MEM/WB destination fields.
module pipeline_hazard_unit
  import pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 16
)(
  input  logic            clk,
  input  logic            reset_n,
  pipeline_hazard_unit_if.slave hz
);
  localparam int NOPS = 3;

  shadow_t                r_ex, r_mem, r_wb;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_stall;
  logic [NOPS-1:0][NREG_W-1:0] w_src;
  logic [NOPS-1:0][1:0]        w_sel;

  // Only a load still in EX has no data yet; everything older is forwardable.
  assign w_stall = hz.id_valid && r_ex.is_load &&
                   ((hz.id_rn_used     && hit(r_ex, hz.id_rn)) ||
                    (hz.id_rm_used     && hit(r_ex, hz.id_rm)) ||
                    (hz.id_rd_src_used && hit(r_ex, hz.id_rd_src)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_ex  <= '{dest:    hz.id_dest,
                 we:      hz.id_valid && hz.id_dest_we && !w_stall,
                 is_load: hz.id_valid && hz.id_is_load && !w_stall};
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign w_src[0] = hz.id_rn;
  assign w_src[1] = hz.id_rm;
  assign w_src[2] = hz.id_rd_src;

  for (genvar g = 0; g < NOPS; g++) begin : g_fwd
    fwd_select u_fwd (
      .i_ex  (r_ex),
      .i_mem (r_mem),
      .i_wb  (r_wb),
      .i_reg (w_src[g]),
      .o_sel (w_sel[g])
    );
  end

  assign hz.fwd_a_sel  = w_sel[0];
  assign hz.fwd_b_sel  = w_sel[1];
  assign hz.fwd_c_sel  = w_sel[2];
  assign hz.pc_ld      = !w_stall;
  assign hz.ifid_ld    = !w_stall;
  assign hz.cu_nop_sel = w_stall;
  // A stalled branch stays in ID and resolves again next cycle.
  assign hz.if_flush   = hz.id_br_taken && hz.id_valid && !w_stall;
  assign hz.stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed checks of stall, flush, forwarding and the saturating stall counter.
module tb_pipeline_hazard_unit;
  // Narrow counter so saturation is reachable in a short run.
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   nchk = 0;
  int   nerr = 0;

  pipeline_hazard_unit_if #(.STALL_CNT_W(CW)) hz ();

  pipeline_hazard_unit #(.STALL_CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rn, input logic rnu,
                       input logic [3:0] rm, input logic rmu,
                       input logic [3:0] rds, input logic rdsu,
                       input logic [3:0] dst, input logic we, input logic ld,
                       input logic br);
    hz.id_valid = v;   hz.id_rn = rn;   hz.id_rn_used = rnu;
    hz.id_rm = rm;     hz.id_rm_used = rmu;
    hz.id_rd_src = rds; hz.id_rd_src_used = rdsu;
    hz.id_dest = dst;  hz.id_dest_we = we; hz.id_is_load = ld;
    hz.id_br_taken = br;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) tick();
  endtask

  // Helpers for common instruction shapes.
  task automatic alu_wr(input logic [3:0] d);
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, d, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic ldr(input logic [3:0] d);
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".pc_ld"},   16'(hz.pc_ld),      16'h1);
    chk({tag, ".ifid_ld"}, 16'(hz.ifid_ld),    16'h1);
    chk({tag, ".nop"},     16'(hz.cu_nop_sel), 16'h0);
    chk({tag, ".flush"},   16'(hz.if_flush),   16'h0);
    chk({tag, ".fwd"},     16'({hz.fwd_a_sel, hz.fwd_b_sel, hz.fwd_c_sel}), 16'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    nop();
    chk_idle("rst");
    chk("rst.cnt", 16'(hz.stall_cnt), 16'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_idle("idle");

    // ALU forwarding at distance 1..4
    for (int gap = 0; gap < 4; gap++) begin
      drain();
      alu_wr(4'd1);
      tick();
      for (int n = 0; n < gap; n++) begin nop(); tick(); end
      drive(1'b1, 4'd1, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
      chk($sformatf("alu.gap%0d.a", gap), 16'(hz.fwd_a_sel), 16'(gap == 3 ? 0 : gap + 1));
      chk($sformatf("alu.gap%0d.b", gap), 16'(hz.fwd_b_sel), 16'h0);
      chk($sformatf("alu.gap%0d.pc", gap), 16'(hz.pc_ld), 16'h1);
      tick();
    end

    // Load-use on rn/rm
    drain();
    ldr(4'd4);
    tick();
    drive(1'b1, 4'd4, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("lu.pc_ld",   16'(hz.pc_ld),      16'h0);
    chk("lu.ifid_ld", 16'(hz.ifid_ld),    16'h0);
    chk("lu.nop",     16'(hz.cu_nop_sel), 16'h1);
    tick();
    chk("lu2.pc_ld",  16'(hz.pc_ld),      16'h1);
    chk("lu2.nop",    16'(hz.cu_nop_sel), 16'h0);
    chk("lu2.a",      16'(hz.fwd_a_sel),  16'h2);
    chk("lu2.b",      16'(hz.fwd_b_sel),  16'h2);
    chk("lu2.cnt",    16'(hz.stall_cnt),  16'h1);
    tick();

    // Load then store of the loaded value
    drain();
    ldr(4'd6);
    tick();
    drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("st.pc_ld", 16'(hz.pc_ld), 16'h0);
    tick();
    chk("st2.pc_ld", 16'(hz.pc_ld),     16'h1);
    chk("st2.c",     16'(hz.fwd_c_sel), 16'h2);
    chk("st2.a",     16'(hz.fwd_a_sel), 16'h0);
    chk("st2.cnt",   16'(hz.stall_cnt), 16'h2);
    tick();

    // Load followed by unrelated reader: no stall
    drain();
    ldr(4'd6);
    tick();
    drive(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("unrel.pc_ld", 16'(hz.pc_ld), 16'h1);
    tick();

    // Branch flush, alone and under a stall
    drain();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("br.flush", 16'(hz.if_flush), 16'h1);
    chk("br.pc_ld", 16'(hz.pc_ld),    16'h1);
    tick();
    nop();
    chk("br.after", 16'(hz.if_flush), 16'h0);
    ldr(4'd8);
    tick();
    drive(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("brst.flush", 16'(hz.if_flush), 16'h0);
    chk("brst.pc_ld", 16'(hz.pc_ld),    16'h0);
    tick();
    chk("brst2.flush", 16'(hz.if_flush), 16'h1);
    chk("brst2.pc_ld", 16'(hz.pc_ld),    16'h1);
    chk("brst2.cnt",   16'(hz.stall_cnt), 16'h3);
    tick();

    // Youngest producer wins
    drain();
    alu_wr(4'd1); tick();
    alu_wr(4'd1); tick();
    drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    chk("prio.a", 16'(hz.fwd_a_sel), 16'h1);
    tick();

    // R15 is never forwarded nor stalled on
    drain();
    ldr(4'd15); tick();
    drive(1'b1, 4'd15, 1'b1, 4'd15, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    chk("pc.a",     16'(hz.fwd_a_sel), 16'h0);
    chk("pc.b",     16'(hz.fwd_b_sel), 16'h0);
    chk("pc.pc_ld", 16'(hz.pc_ld),     16'h1);
    tick();

    // BL writes R14, forwarded normally
    drain();
    alu_wr(4'd14); tick();
    drive(1'b1, 4'd0, 1'b0, 4'd14, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    chk("bl.b", 16'(hz.fwd_b_sel), 16'h1);
    tick();

    // Counter saturation: LDR R4,[R4] repeated stalls every other cycle
    drain();
    drive(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      tick();
      tick();
    end
    chk("sat.cnt", 16'(hz.stall_cnt), 16'hFF);

    // Reset in the middle of a stall
    drain();
    ldr(4'd4); tick();
    drive(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("mrst.pre", 16'(hz.pc_ld), 16'h0);
    reset_n = 1'b0;
    #1;
    chk("mrst.pc_ld", 16'(hz.pc_ld),      16'h1);
    chk("mrst.nop",   16'(hz.cu_nop_sel), 16'h0);
    chk("mrst.cnt",   16'(hz.stall_cnt),  16'h0);
    nop();
    chk_idle("mrst");
    tick();
    reset_n = 1'b1;
    tick();
    chk_idle("post");
    chk("post.cnt", 16'(hz.stall_cnt), 16'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
